pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_lock_supervisor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// ============================================================================
//  Module      : pll_sup_pkg
//  Description : Shared state encoding, default parameters and a sizing helper
//                for the PLL lock supervisor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } sup_state_t;

    localparam int unsigned c_DEF_N_DOM           = 2;
    localparam int unsigned c_DEF_PLL_RST_CYC     = 16;
    localparam int unsigned c_DEF_LOCK_STABLE_CYC = 1024;
    localparam int unsigned c_DEF_STAGE_CYC       = 8;
    localparam int unsigned c_DEF_TIMEOUT_CYC     = 65536;
    localparam int unsigned c_DEF_CNT_W           = 8;

    // Largest of the four cycle parameters; sizes the shared phase timer.
    function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
//  Module      : pll_lock_supervisor
//  Description : Sequences PLL reset, waits for a stable lock, then releases
//                the downstream reset domains one by one; tracks lock losses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned N_DOM           = c_DEF_N_DOM,
    parameter int unsigned PLL_RST_CYC     = c_DEF_PLL_RST_CYC,
    parameter int unsigned LOCK_STABLE_CYC = c_DEF_LOCK_STABLE_CYC,
    parameter int unsigned STAGE_CYC       = c_DEF_STAGE_CYC,
    parameter int unsigned TIMEOUT_CYC     = c_DEF_TIMEOUT_CYC,
    parameter int unsigned CNT_W           = c_DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic [N_DOM-1:0] dom_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic             timeout_err
);

    // One timer serves every phase, so it is sized for the longest one.
    localparam int unsigned c_TMR_W =
        $clog2(max_cyc(PLL_RST_CYC, LOCK_STABLE_CYC, STAGE_CYC, TIMEOUT_CYC) + 1);

    localparam logic [c_TMR_W-1:0] c_PLL_RST_LAST = c_TMR_W'(PLL_RST_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_STABLE_LAST  = c_TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_STAGE_LAST   = c_TMR_W'(STAGE_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

    sup_state_t          r_state;
    sup_state_t          w_state_nxt;
    logic [c_TMR_W-1:0]  r_cnt;
    logic [c_TMR_W-1:0]  w_cnt_nxt;
    logic                r_pll_rst;
    logic                w_pll_rst_nxt;
    logic [N_DOM-1:0]    r_dom_rst;
    logic [N_DOM-1:0]    w_dom_rst_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic [CNT_W-1:0]    r_lock_loss_cnt;
    logic [CNT_W-1:0]    w_lock_loss_cnt_nxt;
    logic                r_timeout_err;
    logic                w_timeout_err_nxt;
    logic                w_loss_evt;
    logic                w_tmo_evt;
    logic                w_locked_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_locked_s)
    );

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_PLL_RST;
            r_cnt           <= '0;
            r_pll_rst       <= 1'b1;
            r_dom_rst       <= '1;
            r_ready         <= 1'b0;
            r_lock_loss_cnt <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_pll_rst       <= w_pll_rst_nxt;
            r_dom_rst       <= w_dom_rst_nxt;
            r_ready         <= w_ready_nxt;
            r_lock_loss_cnt <= w_lock_loss_cnt_nxt;
            r_timeout_err   <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_pll_rst_nxt       = 1'b0;
        w_dom_rst_nxt       = r_dom_rst;
        w_ready_nxt         = 1'b0;
        w_loss_evt          = 1'b0;
        w_tmo_evt           = 1'b0;
        w_lock_loss_cnt_nxt = r_lock_loss_cnt;
        w_timeout_err_nxt   = r_timeout_err;

        case (r_state)
            ST_PLL_RST: begin
                w_dom_rst_nxt = '1;
                if (r_cnt == c_PLL_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_pll_rst_nxt = 1'b1;
                    w_cnt_nxt     = r_cnt + c_TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_tmo_evt     = 1'b1;
                    w_state_nxt   = ST_PLL_RST;
                    w_cnt_nxt     = '0;
                    w_pll_rst_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_TMR_W'(1);
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt   = ST_RELEASE;
                    w_cnt_nxt     = '0;
                    w_dom_rst_nxt = {N_DOM{1'b1}} << 1;
                end else begin
                    w_cnt_nxt = r_cnt + c_TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                // Zeros shift in from bit 0, so domains release in index order.
                if (!w_locked_s) begin
                    w_loss_evt = 1'b1;
                end else if (r_dom_rst == '0) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end else if (r_cnt == c_STAGE_LAST) begin
                    w_dom_rst_nxt = r_dom_rst << 1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_loss_evt = 1'b1;
                end else begin
                    w_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_PLL_RST;
                w_cnt_nxt     = '0;
                w_pll_rst_nxt = 1'b1;
                w_dom_rst_nxt = '1;
            end
        endcase

        if (w_loss_evt) begin
            w_state_nxt   = ST_PLL_RST;
            w_cnt_nxt     = '0;
            w_pll_rst_nxt = 1'b1;
            w_dom_rst_nxt = '1;
            w_ready_nxt   = 1'b0;
        end

        // A clear coinciding with a new loss still records that loss.
        if (clr_cnt) begin
            w_lock_loss_cnt_nxt = w_loss_evt ? CNT_W'(1) : '0;
        end else if (w_loss_evt && (r_lock_loss_cnt != '1)) begin
            w_lock_loss_cnt_nxt = r_lock_loss_cnt + CNT_W'(1);
        end

        if (w_tmo_evt) begin
            w_timeout_err_nxt = 1'b1;
        end else if (clr_cnt) begin
            w_timeout_err_nxt = 1'b0;
        end
    end

    assign pll_rst       = r_pll_rst;
    assign dom_rst       = r_dom_rst;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign timeout_err   = r_timeout_err;

endmodule

`default_nettype wire
